// File: rtl/ram_arbiter_if.sv
// Bundles the icache, dcache and RAM sides of the unified RAM port.
// The arbiter connects through master; the caches and RAM model use slave.
interface ram_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates the unified RAM port between icache word fetches and dcache two-word block
// bursts, holding the grant across a block and alternating priority between transactions.
module ram_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  ram_arbiter_if.master    bus,
  output logic             ram_err,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] dstall_cnt
);

  localparam int unsigned     LockW     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]      RamAccess = 2'd2;
  localparam logic [1:0]      RamError  = 2'd3;

  typedef enum logic [1:0] {StIdle, StIGrant, StDGrant, StDLock} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;  // 1 = icache wins a tie
  logic [LockW-1:0] lock_q, lock_d;
  logic [CNT_W-1:0] istall_q, istall_d, dstall_q, dstall_d;

  logic        d_req;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  assign d_req = bus.dREN | bus.dWEN;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    lock_d   = lock_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ram_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (d_req && (!bus.iREN || !prio_q)) begin
          state_d = StDGrant;
        end else if (bus.iREN) begin
          state_d = StIGrant;
        end
      end
      StIGrant: begin
        iload = bus.ramload;
        if (!bus.iREN) begin
          state_d = StIdle;
        end else begin
          ramREN  = 1'b1;
          ramaddr = bus.iaddr;
          if (bus.ramstate == RamAccess) begin
            iwait   = 1'b0;
            prio_d  = 1'b0;
            state_d = StIdle;
          end else if (bus.ramstate == RamError) begin
            ram_err = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDGrant: begin
        dload    = bus.ramload;
        ramaddr  = bus.daddr;
        ramstore = bus.dstore;
        if (!d_req) begin
          state_d = StIdle;
        end else begin
          // A write wins when both dcache strobes are raised.
          ramWEN = bus.dWEN;
          ramREN = bus.dREN & ~bus.dWEN;
          if (bus.ramstate == RamAccess) begin
            dwait = 1'b0;
            if (bus.daddr[2]) begin
              prio_d  = 1'b1;
              state_d = StIdle;
            end else begin
              lock_d  = '0;
              state_d = StDLock;
            end
          end else if (bus.ramstate == RamError) begin
            ram_err = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDLock: begin
        if (d_req) begin
          state_d = StDGrant;
        end else if (lock_q == LockLast) begin
          lock_d  = '0;
          prio_d  = 1'b1;
          state_d = StIdle;
        end else begin
          lock_d = lock_q + LockW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating stall counters, independent of arbiter state.
  always_comb begin
    istall_d = istall_q;
    dstall_d = dstall_q;
    if (bus.iREN && iwait && (istall_q != '1)) istall_d = istall_q + CNT_W'(1);
    if (d_req && dwait && (dstall_q != '1)) dstall_d = dstall_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      lock_q   <= '0;
      istall_q <= '0;
      dstall_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      lock_q   <= lock_d;
      istall_q <= istall_d;
      dstall_q <= dstall_d;
    end
  end

  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.ramREN   = ramREN;
  assign bus.ramWEN   = ramWEN;
  assign bus.ramaddr  = ramaddr;
  assign bus.ramstore = ramstore;
  assign istall_cnt   = istall_q;
  assign dstall_cnt   = dstall_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: cache drivers push expected completions, a RAM model
// answers strobes, and completions are popped and compared as the waits drop.
module tb_ram_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ram_arbiter_if bus ();
  ram_arbiter_if bus4 ();
  logic        ram_err, ram_err4;
  logic [31:0] istall_cnt, dstall_cnt;
  logic [3:0]  istall4, dstall4;

  ram_arbiter #(.LOCK_TIMEOUT(4), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .ram_err(ram_err),
    .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
  );

  ram_arbiter #(.LOCK_TIMEOUT(4), .CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .bus(bus4), .ram_err(ram_err4),
    .istall_cnt(istall4), .dstall_cnt(dstall4)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  req_t        i_list[$], d_list[$], exp_i[$], exp_d[$];
  int          lat = 1;
  int          gcnt = 0;
  bit          err_next = 0;
  int          err_pulses = 0;
  logic [63:0] ord = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM contents are a fixed pattern of the address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [63:0] code_of(input string s);
    logic [63:0] c;
    c = '0;
    for (int k = 0; k < s.len(); k++) c = (c << 2) | ((s[k] == "I") ? 64'd1 : 64'd2);
    return c;
  endfunction

  task automatic push_i(input logic [31:0] a);
    req_t r;
    r = '{we: 1'b0, addr: a, data: pat(a)};
    i_list.push_back(r);
    exp_i.push_back(r);
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r = '{we: we, addr: a, data: d};
    d_list.push_back(r);
    r.data = we ? d : pat(a);
    exp_d.push_back(r);
  endtask

  // One clock: drive caches, answer from RAM model, then observe and score.
  task automatic step();
    req_t e;
    @(posedge CLK);
    @(negedge CLK);
    if (i_list.size() != 0) begin
      bus.iREN  = 1'b1;
      bus.iaddr = i_list[0].addr;
    end else begin
      bus.iREN  = 1'b0;
      bus.iaddr = '0;
    end
    if (d_list.size() != 0) begin
      bus.dREN   = ~d_list[0].we;
      bus.dWEN   = d_list[0].we;
      bus.daddr  = d_list[0].addr;
      bus.dstore = d_list[0].data;
    end else begin
      bus.dREN   = 1'b0;
      bus.dWEN   = 1'b0;
      bus.daddr  = '0;
      bus.dstore = '0;
    end
    #1;
    if (bus.ramREN || bus.ramWEN) begin
      gcnt++;
      if (err_next) begin
        err_next     = 0;
        gcnt         = 0;
        bus.ramstate = ERROR;
        bus.ramload  = 32'hBAD0_BAD0;
      end else if (gcnt >= lat) begin
        gcnt         = 0;
        bus.ramstate = ACCESS;
        bus.ramload  = bus.ramREN ? pat(bus.ramaddr) : 32'hBAD1_BAD1;
      end else begin
        bus.ramstate = BUSY;
        bus.ramload  = 32'hBAD2_BAD2;
      end
    end else begin
      gcnt         = 0;
      bus.ramstate = FREE;
      bus.ramload  = 32'hBAD3_BAD3;
    end
    #1;
    check("ren_wen_excl", bus.ramREN & bus.ramWEN, 0);
    check("one_grant", !bus.iwait && !bus.dwait, 0);
    if (ram_err) err_pulses++;
    if (bus.ramstate == ERROR) begin
      check("err_pulse", ram_err, 1);
      check("err_waits", bus.iwait & bus.dwait, 1);
    end else begin
      check("err_quiet", ram_err, 0);
    end
    if (!bus.ramREN && !bus.ramWEN) begin
      check("iload_gate", bus.iload, 0);
      check("dload_gate", bus.dload, 0);
    end
    if (!bus.iwait) begin
      ord = (ord << 2) | 64'd1;
      check("i_on_access", bus.ramstate == ACCESS, 1);
      if (exp_i.size() == 0) begin
        check("i_unexpected", 1, 0);
      end else begin
        e = exp_i.pop_front();
        void'(i_list.pop_front());
        check("i_ramaddr", bus.ramaddr, e.addr);
        check("iload", bus.iload, e.data);
      end
    end
    if (!bus.dwait) begin
      ord = (ord << 2) | 64'd2;
      check("d_on_access", bus.ramstate == ACCESS, 1);
      if (exp_d.size() == 0) begin
        check("d_unexpected", 1, 0);
      end else begin
        e = exp_d.pop_front();
        void'(d_list.pop_front());
        check("d_ramaddr", bus.ramaddr, e.addr);
        if (e.we) begin
          check("d_ramWEN", bus.ramWEN, 1);
          check("d_ramstore", bus.ramstore, e.data);
        end else begin
          check("d_ramREN", bus.ramREN, 1);
          check("dload", bus.dload, e.data);
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((i_list.size() + d_list.size()) != 0 && n < max) begin
      step();
      n++;
    end
    check(tag, i_list.size() + d_list.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramstate = FREE; bus.ramload = 32'hDEAD_BEEF;
    bus4.iREN = 0; bus4.iaddr = 0; bus4.dREN = 0; bus4.dWEN = 0; bus4.daddr = 0;
    bus4.dstore = 0; bus4.ramstate = BUSY; bus4.ramload = 0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    check("rst_iwait", bus.iwait, 1);
    check("rst_dwait", bus.dwait, 1);
    check("rst_ramREN", bus.ramREN, 0);
    check("rst_ramWEN", bus.ramWEN, 0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_ramstore", bus.ramstore, 0);
    check("rst_iload", bus.iload, 0);
    check("rst_dload", bus.dload, 0);
    check("rst_ram_err", ram_err, 0);
    check("rst_istall", istall_cnt, 0);
    check("rst_dstall", dstall_cnt, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Single icache fetch, ACCESS on the second grant cycle.
    lat = 2;
    push_i(32'h40);
    step();
    check("t1_idle_no_ren", bus.ramREN, 0);
    step();
    check("t1_ren_rise", bus.ramREN, 1);
    check("t1_addr", bus.ramaddr, 32'h40);
    check("t1_wait_busy", bus.iwait, 1);
    step();
    check("t1_iwait_low", bus.iwait, 0);
    check("t1_iload", bus.iload, 32'h8C01_0004);
    step();
    check("t1_iwait_back", bus.iwait, 1);
    check("t1_ren_off", bus.ramREN, 0);
    check("t1_istall", istall_cnt, 2);
    check("t1_dstall", dstall_cnt, 0);

    // Dcache block must not be split by a waiting icache fetch.
    lat = 1;
    ord = '0;
    push_d(1'b0, 32'h100, 32'h0);
    push_d(1'b0, 32'h104, 32'h0);
    push_i(32'h80);
    drain("t2_drain", 40);
    check("t2_order", ord, code_of("DDI"));

    // Continuous contention alternates block / word.
    ord = '0;
    for (int k = 0; k < 3; k++) begin
      push_d(1'b1, 32'h200, 32'hA000_0000 + k);
      push_d(1'b1, 32'h204, 32'hB000_0000 + k);
      push_i(32'h10 + 4 * k);
    end
    drain("t3_drain", 80);
    check("t3_order", ord, code_of("DDIDDIDDI"));

    // Lock released after 4 idle cycles, pending icache then granted.
    push_d(1'b0, 32'h300, 32'h0);
    push_i(32'h84);
    n = 0;
    while (d_list.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check("t4_word0_done", d_list.size(), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t4_lock_quiet", bus.ramREN | bus.ramWEN, 0);
    end
    step();
    check("t4_igrant_ren", bus.ramREN, 1);
    check("t4_igrant_addr", bus.ramaddr, 32'h84);
    drain("t4_drain", 10);

    // RAM error during a dcache write; same write retried.
    err_pulses = 0;
    err_next   = 1;
    push_d(1'b1, 32'h404, 32'h1234_5678);
    drain("t5_drain", 20);
    check("t5_err_pulses", err_pulses, 1);

    // Narrow counters saturate.
    bus4.iREN  = 1'b1;
    bus4.iaddr = 32'h7C;
    for (int k = 0; k < 10; k++) step();
    check("t6_istall_10", istall4, 10);
    for (int k = 0; k < 10; k++) step();
    check("t6_istall_sat", istall4, 15);
    check("t6_ren", bus4.ramREN, 1);
    check("t6_addr", bus4.ramaddr, 32'h7C);
    check("t6_iwait", bus4.iwait, 1);
    check("t6_dwait", bus4.dwait, 1);
    check("t6_err", ram_err4, 0);
    check("t6_dstall", dstall4, 0);
    bus4.iREN = 1'b0;

    // Reset in the middle of a dcache write grant.
    lat = 20;
    push_d(1'b1, 32'h500, 32'hCAFE_F00D);
    n = 0;
    while (!bus.ramWEN && n < 5) begin
      step();
      n++;
    end
    check("t7_in_grant", bus.ramWEN, 1);
    #1 nRST = 1'b0;
    #1;
    check("t7_wen_fall", bus.ramWEN, 0);
    check("t7_iwait", bus.iwait, 1);
    check("t7_dwait", bus.dwait, 1);
    check("t7_ramaddr", bus.ramaddr, 0);
    check("t7_ramstore", bus.ramstore, 0);
    check("t7_dstall", dstall_cnt, 0);
    d_list.delete();
    exp_d.delete();
    bus.dWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t7_no_strobe", bus.ramREN | bus.ramWEN, 0);
    end
    lat = 1;
    push_i(32'h44);
    drain("t7_recover", 10);

    check("end_exp_i", exp_i.size(), 0);
    check("end_exp_d", exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Arbitrates the single unified RAM port between the instruction cache (word fetches) and the data cache (word reads/writes, issued as two-word block bursts).
- Sits between the caches and the RAM model, and owns all ramREN/ramWEN sequencing.
- Holds the grant across a dcache block burst so the two words of a block are never split by an icache fetch.
- Alternates priority after each completed transaction to prevent starvation.

Parameters:
- LOCK_TIMEOUT, 4: idle cycles after dcache word 0 before a held burst lock is released.
- CNT_W, 32: width of the saturating stall counters.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  1 = icache must hold its request.
- iload  out  32  fetched instruction word.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address; bit 2 selects word 0/1 of the block.
- dstore  in  32  dcache write data.
- dwait  out  1  1 = dcache must hold its request.
- dload  out  32  dcache read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- ramload  in  32  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ram_err  out  1  one-cycle pulse on ramstate ERROR.
- istall_cnt  out  CNT_W  cycles with iREN=1 and iwait=1, saturating.
- dstall_cnt  out  CNT_W  cycles with (dREN|dWEN)=1 and dwait=1, saturating.

Behaviour:
- Reset values (asynchronous): state IDLE; iwait=1, dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0; ram_err=0; both counters 0; priority bit = dcache; lock timer 0.
- Always true: iwait and dwait stay 1 except in the single cycle that grantee sees ramstate==ACCESS.
- Always true: ramREN and ramWEN are never both 1.
- dREN and dWEN both asserted: dWEN wins.
- Data outputs: iload and dload pass ramload through combinationally. Each is 0 when its requester is not granted.
- State IDLE:
  - No RAM enables driven.
  - Only dcache requests: go to DGRANT.
  - Only iREN: go to IGRANT.
  - Both requesting: the priority bit decides.
  - Arbitration latency is 1 cycle; RAM enables first assert in the grant state.
- State IGRANT:
  - ramREN=1, ramaddr=iaddr.
  - On ACCESS: iwait=0 that cycle, priority bit set to dcache, go to IDLE.
  - iREN dropping before ACCESS: go to IDLE without asserting the strobe.
- State DGRANT:
  - RAM port driven from the dcache signals (ramaddr=daddr, ramstore=dstore).
  - On ACCESS with daddr[2]==0: dwait=0 that cycle, go to DLOCK, clear lock timer.
  - On ACCESS with daddr[2]==1: dwait=0, priority bit set to icache, go to IDLE.
  - dcache request dropping before ACCESS: go to IDLE.
- State DLOCK:
  - No RAM enables driven; the icache is not granted.
  - dcache request present: go to DGRANT next cycle.
  - Otherwise the lock timer increments; at LOCK_TIMEOUT go to IDLE with the priority bit set to icache.
- On ramstate ERROR in either grant state:
  - ram_err=1 for one cycle.
  - The grantee's wait stays 1.
  - Go to IDLE; the priority bit is unchanged, so the same requester retries.
- FREE/BUSY in a grant state: hold the state and all outputs.
- Stall counters:
  - Increment every qualifying cycle and saturate at all-ones; no wrap.
  - Counting is independent of state, so stalls in IDLE and DLOCK also count.
- Reset mid-burst:
  - All outputs return to their reset values immediately.
  - The lock is discarded and no pending strobe completes.

Test Plan:
- Reset then iREN=1, iaddr=0x40, RAM answers ACCESS on the 2nd grant cycle with ramload=0x8C010004:
  - ramREN rises 1 cycle after the request.
  - iwait=0 and iload=0x8C010004 for exactly 1 cycle, then IDLE.
- dREN word 0 at 0x100 then word 1 at 0x104, with iREN=1 held throughout:
  - Both dcache words complete back-to-back.
  - ramREN is never driven with iaddr between them.
  - The icache is granted next.
- Both request continuously (iREN, and dWEN with daddr alternating 0x200/0x204):
  - Grants alternate: full 2-word dcache block, then 1 icache word, then block, and so on.
  - No requester waits more than 2 transactions.
- dcache word 0 completes, then the dcache goes idle for 4 cycles:
  - DLOCK releases after LOCK_TIMEOUT=4.
  - A pending iREN is granted on the next cycle.
- ramstate=ERROR during a dcache write:
  - ram_err pulses once and dwait stays 1.
  - The dcache retries with the same daddr/dstore on the next grant.
- With CNT_W overridden to 4, hold iREN with the RAM BUSY for 20 cycles:
  - istall_cnt saturates at 15.
- Assert nRST=0 mid-DGRANT:
  - ramWEN falls asynchronously and both waits go to 1.
